cnn16_ram_arbiter: RTL
======================

Name: cnn16_ram_arbiter

Overview:
- Shares one single-port cnn16_ram instance between two requesters: port 0 (weight/feature loader) and port 1 (conv engine).
- Arbitrates round-robin, with optional burst lock and bounded starvation.
- Registers the RAM command, tracks read returns and routes read data back to the issuing port.
- Sits between the CNN datapath engines and the RAM; the RAM itself is unchanged.

Parameters:
- DATA_WIDTH, 16: word width; matches the RAM.
- ADDR_WIDTH, 12: address width; matches the RAM.
- LOCK_MAX, 16: maximum consecutive locked grants to one port while the other port is requesting; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held with its command until gnt0
- we0  in  1  port 0 write (1) / read (0)
- lock0  in  1  port 0 keeps ownership for the next cycle
- addr0  in  ADDR_WIDTH  port 0 address
- wdata0  in  DATA_WIDTH  port 0 write data
- gnt0  out  1  port 0 command accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_WIDTH  port 0 read data
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_write  out  1  to RAM mem_write (registered)
- mem_address  out  ADDR_WIDTH  to RAM address (registered)
- mem_data_in  out  DATA_WIDTH  to RAM data_in (registered)
- mem_data_out  in  DATA_WIDTH  from RAM data_out

Behaviour:
- Reset (async, rst_n=0): mem_write=0, mem_address=0, mem_data_in=0, rvalid0=rvalid1=0, priority pointer=port 0, owner=none, lock counter=0. gnt0 and gnt1 are 0 while in reset.
- Arbitration, combinational each cycle: at most one gnt is high.
  - Only one port requesting: that port is granted.
  - Both requesting, no active lock: the port named by the priority pointer is granted.
  - After each grant the pointer moves to the other port.
- Lock:
  - A port granted with lockN=1 becomes owner for the next cycle.
  - While the owner's reqN=1, the owner is granted even if the other port requests, and the pointer does not advance.
  - The lock counter increments on each locked grant made while the other port is requesting.
  - When the counter reaches LOCK_MAX, the next arbitration ignores the lock and grants the other port. The counter then clears.
  - Ownership and the counter also clear when the owner drops reqN or lockN.
- Command pipeline: on the clk edge ending grant cycle T, mem_write, mem_address and mem_data_in load the granted command.
  - No grant: mem_write<=0; address and data hold their values.
  - A write reaches the RAM in T+1.
- Read return:
  - A 2-stage tag pipe (valid + port id) follows each granted read.
  - rvalidN=1 in cycle T+2, for exactly one cycle.
  - rdataN = mem_data_out, routed combinationally. rdataN is don't-care when rvalidN=0; it is driven with mem_data_out regardless.
- Throughput: one command per cycle. Back-to-back reads return one per cycle in issue order. Read-after-write to the same address, issued in consecutive cycles, returns the new data.
- Writes produce no rvalid.
- Idle cycles: the RAM performs a read of the held address; no rvalid is generated.
- Reset mid-operation: in-flight tags are discarded and no rvalid is emitted after reset. A write already registered but not yet clocked into the RAM is dropped.
- Requester contract: reqN/weN/addrN/wdataN stay stable until gntN=1; reqN may then drop or present a new command in the next cycle.

Test Plan:
- Reset, then port 0 writes 0x1234 to addr 0x005, then reads addr 0x005 -> gnt0 immediately for both commands; rvalid0=1 exactly 2 cycles after the read grant with rdata0=0x1234; rvalid1 stays 0.
- Both ports request reads every cycle, no lock -> grants alternate 0,1,0,1; each rvalidN occurs 2 cycles after its own grant, with the data from its own address.
- Port 1 locked burst of 40 reads (lock1=1) while port 0 requests continuously, LOCK_MAX=16 -> port 1 receives 16 consecutive grants, port 0 receives 1 grant, then port 1 resumes.
- Write 0xBEEF to addr 0xFFF, read addr 0xFFF in the next cycle (address wrap boundary, RAW hazard) -> read returns 0xBEEF.
- Issue reads at cycles T and T+1, then assert rst_n=0 at T+1 for one cycle -> no rvalid0 or rvalid1 ever fires; all outputs are at reset values during reset.
- Single requester with req held continuously and we toggling between write and read -> gnt stays high every cycle, mem_write follows we delayed by one cycle, and there are no gaps in the command stream.

Source files
------------

// File: rtl/cnn16_ram_arbiter.sv
// cnn16_ram_arbiter: round-robin arbiter sharing one single-port RAM between two requesters,
// with burst lock, bounded starvation, a registered RAM command and tagged read-data return.
module cnn16_ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    localparam logic [7:0] LMAX = 8'(LOCK_MAX);
    logic                  own_v, own_id, ptr;
    logic [7:0]            cnt;
    logic                  held, any, gid, g_we, g_lock, oreq;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic                  t1_v, t1_id, t2_v, t2_id;
    // held: the owner keeps the RAM until its streak against a waiting port hits LOCK_MAX
    always_comb begin
        held    = own_v && (own_id ? req1 : req0) && cnt < LMAX;
        any     = rst_n && (req0 || req1);
        gid     = held ? own_id : (req0 && req1) ? ptr : req1;
        g_we    = gid ? we1 : we0;
        g_lock  = gid ? lock1 : lock0;
        g_addr  = gid ? addr1 : addr0;
        g_wdata = gid ? wdata1 : wdata0;
        oreq    = gid ? req0 : req1;
    end
    assign gnt0    = any && !gid;
    assign gnt1    = any && gid;
    assign rvalid0 = t2_v && !t2_id;
    assign rvalid1 = t2_v && t2_id;
    assign rdata0  = mem_data_out;
    assign rdata1  = mem_data_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            t1_v        <= 1'b0;
            t1_id       <= 1'b0;
            t2_v        <= 1'b0;
            t2_id       <= 1'b0;
            ptr         <= 1'b0;
            own_v       <= 1'b0;
            own_id      <= 1'b0;
            cnt         <= '0;
        end else begin
            mem_write <= any && g_we;
            if (any) begin
                mem_address <= g_addr;
                mem_data_in <= g_wdata;
            end
            t1_v  <= any && !g_we;
            t1_id <= gid;
            t2_v  <= t1_v;
            t2_id <= t1_id;
            if (any && !held) ptr <= !gid;
            own_v  <= any && g_lock;
            own_id <= gid;
            cnt    <= (any && g_lock) ? (held ? cnt : 8'd0) + {7'd0, oreq} : 8'd0;
        end
    end
endmodule
